// File: rtl/debug_uart_tx.sv
// Debug serial transmitter: I/O writes are queued in a 16-entry FIFO and sent as 8N1 on oTx.
// Latency: a data-port write in cycle N is popped in N+1 and the start bit begins in N+2. Reads answer in N+1.
// Backpressure: none toward the CPU. A write to a full FIFO with no pop that cycle is dropped and sets sticky ovf.
// Ports: iClk/iReset (async, active high); iCpuAddr[7:0] decoded; iCpuData write data;
//        iCpuIoRd/iCpuIoWr level strobes (rising edge = one access); oCpuData/oCpuSel registered read result;
//        oTx serial line (idles high); oBusy = frame in flight or FIFO non-empty.
module debug_uart_tx #(
  parameter int unsigned CLK_HZ    = 10_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [7:0]  PORT_DATA = 8'hF8,
  parameter logic [7:0]  PORT_STAT = 8'hF9
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [19:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuIoRd,
  input  logic        iCpuIoWr,
  output logic [7:0]  oCpuData,
  output logic        oCpuSel,
  output logic        oTx,
  output logic        oBusy
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Only the low address byte is decoded for I/O space.
  logic [7:0] addr_lo;
  logic       unused_addr_hi;
  assign addr_lo        = iCpuAddr[7:0];
  assign unused_addr_hi = ^iCpuAddr[19:8];

  // Strobe history turns level strobes into single accesses.
  logic rd_q, wr_q;
  logic rd_acc, wr_acc;
  assign rd_acc = iCpuIoRd & ~rd_q;
  assign wr_acc = iCpuIoWr & ~wr_q;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= iCpuIoRd;
      wr_q <= iCpuIoWr;
    end
  end

  // FIFO storage and bookkeeping.
  logic [7:0] mem [16];
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;
  logic       fifo_empty, fifo_full;
  logic       push_req, push_ok, pop;
  logic [4:0] free;

  assign fifo_empty = (count == 5'd0);
  assign fifo_full  = (count == 5'd16);
  assign free       = 5'd16 - count;
  assign push_req   = wr_acc && (addr_lo == PORT_DATA);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge iClk) begin
    if (push_ok) mem[wr_ptr] <= iCpuData;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      count  <= 5'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 4'd1;
      if (pop)     rd_ptr <= rd_ptr + 4'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Transmit state machine.
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          busy_shift;

  assign busy_shift = (state != S_IDLE);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
      oTx   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      oTx   <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          cnt_nxt   = BIT_LAST;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          cnt_nxt   = BIT_LAST;
          idx_nxt   = 3'd0;
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_nxt   = BIT_LAST;
          shift_nxt = {1'b0, shift[7:1]};
          if (idx == 3'd7) state_nxt = S_STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            cnt_nxt   = BIT_LAST;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // oTx is computed from the next state so the flop output lines up with the state register.
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  assign oBusy = busy_shift | ~fifo_empty;

  // Sticky overflow; a status read returns the old value and clears it, a new overflow wins.
  logic ovf;
  logic stat_rd;
  assign stat_rd = rd_acc && (addr_lo == PORT_STAT);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)                              ovf <= 1'b0;
    else if (push_req && fifo_full && !pop)  ovf <= 1'b1;
    else if (stat_rd)                        ovf <= 1'b0;
  end

  // Registered read path; non-matching reads deselect but keep the last data.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oCpuData <= 8'h00;
      oCpuSel  <= 1'b0;
    end else if (rd_acc) begin
      if (addr_lo == PORT_STAT) begin
        oCpuData <= {4'b0, ovf, busy_shift, fifo_empty, fifo_full};
        oCpuSel  <= 1'b1;
      end else if (addr_lo == PORT_DATA) begin
        oCpuData <= {3'b0, free};
        oCpuSel  <= 1'b1;
      end else begin
        oCpuSel  <= 1'b0;
      end
    end
  end

endmodule
